// File: rtl/election_cooldown_pkg.sv
// Shared types and constants for the election house controller.
// The state enum, widths and winner codes are used by the interface, the top and the bench.
package election_pkg;

   typedef enum logic [1:0] {
      READY   = 2'd0,
      COOLING = 2'd1,
      WON     = 2'd2
   } election_state_t;

   localparam int VOTE_W      = 4;
   localparam int FRAME_CNT_W = 8;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;

   // A tally that has reached its ceiling holds there.
   function automatic logic [VOTE_W-1:0] sat_inc(input logic [VOTE_W-1:0] tally,
                                                 input int max_votes);
      if (int'(tally) >= max_votes)
         return tally;
      return tally + VOTE_W'(1);
   endfunction

endpackage

// File: rtl/election_cooldown_if.sv
// Frame, collision and scoring signals between the game logic and the election controller.
// The master side drives frame/collision inputs; the slave side is the controller.
interface election_if;
   import election_pkg::*;

   logic                   startOfFrame;
   logic                   gameActive;
   logic                   collisionP1;
   logic                   collisionP2;
   logic                   coolingDown;
   logic [FRAME_CNT_W-1:0] framesLeft;
   logic                   voteP1;
   logic                   voteP2;
   logic [VOTE_W-1:0]      votesP1;
   logic [VOTE_W-1:0]      votesP2;
   logic [1:0]             winner;

   modport master (
      output startOfFrame, gameActive, collisionP1, collisionP2,
      input  coolingDown, framesLeft, voteP1, voteP2, votesP1, votesP2, winner
   );

   modport slave (
      input  startOfFrame, gameActive, collisionP1, collisionP2,
      output coolingDown, framesLeft, voteP1, voteP2, votesP1, votesP2, winner
   );

endinterface

// File: rtl/election_cooldown_frame_hit_latch.sv
// Sticky per-frame hit flag: set by a collision, cleared when the frame closes.
// Clear wins over set so a collision in the closing cycle never leaks into the next frame.
module frame_hit_latch (
   input  logic clk,
   input  logic reset,
   input  logic set,
   input  logic clear,
   output logic hit
);

   always_ff @(posedge clk) begin
      if (reset || clear)
         hit <= 1'b0;
      else if (set)
         hit <= 1'b1;
   end

endmodule

// File: rtl/election_cooldown.sv
// Election house controller: awards one vote per captured frame, then locks the house
// for a number of frames, keeps saturating tallies and latches the winner.
module election_cooldown
   import election_pkg::*;
#(
   parameter int COOLDOWN_FRAMES = 180,
   parameter int MAX_VOTES       = 9,
   parameter int VOTES_TO_WIN    = 5
) (
   input logic     clk,
   input logic     reset,
   election_if.slave bus
);

   election_state_t        state_q, state_d;
   logic [FRAME_CNT_W-1:0] counter_q, counter_d;
   logic [VOTE_W-1:0]      votes_p1_q, votes_p1_d;
   logic [VOTE_W-1:0]      votes_p2_q, votes_p2_d;
   logic [1:0]             winner_q, winner_d;
   logic                   vote_p1_q, vote_p1_d;
   logic                   vote_p2_q, vote_p2_d;
   logic                   hit_p1, hit_p2;
   logic                   frame_p1, frame_p2;
   logic                   flag_clear;

   assign flag_clear = bus.startOfFrame | ~bus.gameActive;

   frame_hit_latch u_hit_p1 (
      .clk   (clk),
      .reset (reset),
      .set   (bus.collisionP1),
      .clear (flag_clear),
      .hit   (hit_p1)
   );

   frame_hit_latch u_hit_p2 (
      .clk   (clk),
      .reset (reset),
      .set   (bus.collisionP2),
      .clear (flag_clear),
      .hit   (hit_p2)
   );

   // A collision in the closing cycle still belongs to the frame being closed.
   assign frame_p1 = hit_p1 | bus.collisionP1;
   assign frame_p2 = hit_p2 | bus.collisionP2;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= READY;
         counter_q  <= '0;
         votes_p1_q <= '0;
         votes_p2_q <= '0;
         winner_q   <= WIN_NONE;
         vote_p1_q  <= 1'b0;
         vote_p2_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         counter_q  <= counter_d;
         votes_p1_q <= votes_p1_d;
         votes_p2_q <= votes_p2_d;
         winner_q   <= winner_d;
         vote_p1_q  <= vote_p1_d;
         vote_p2_q  <= vote_p2_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      counter_d  = counter_q;
      votes_p1_d = votes_p1_q;
      votes_p2_d = votes_p2_q;
      winner_d   = winner_q;
      vote_p1_d  = 1'b0;
      vote_p2_d  = 1'b0;

      if (!bus.gameActive) begin
         state_d    = READY;
         counter_d  = '0;
         votes_p1_d = '0;
         votes_p2_d = '0;
         winner_d   = WIN_NONE;
      end else if (bus.startOfFrame) begin
         case (state_q)
            READY: begin
               // Contested frames (both players) award nothing.
               if (frame_p1 && !frame_p2) begin
                  vote_p1_d  = 1'b1;
                  votes_p1_d = sat_inc(votes_p1_q, MAX_VOTES);
                  if (votes_p1_d >= VOTE_W'(VOTES_TO_WIN)) begin
                     winner_d  = WIN_P1;
                     state_d   = WON;
                     counter_d = '0;
                  end else begin
                     state_d   = COOLING;
                     counter_d = FRAME_CNT_W'(COOLDOWN_FRAMES);
                  end
               end else if (frame_p2 && !frame_p1) begin
                  vote_p2_d  = 1'b1;
                  votes_p2_d = sat_inc(votes_p2_q, MAX_VOTES);
                  if (votes_p2_d >= VOTE_W'(VOTES_TO_WIN)) begin
                     winner_d  = WIN_P2;
                     state_d   = WON;
                     counter_d = '0;
                  end else begin
                     state_d   = COOLING;
                     counter_d = FRAME_CNT_W'(COOLDOWN_FRAMES);
                  end
               end
            end
            COOLING: begin
               if (counter_q <= FRAME_CNT_W'(1)) begin
                  counter_d = '0;
                  state_d   = READY;
               end else begin
                  counter_d = counter_q - FRAME_CNT_W'(1);
               end
            end
            WON: begin
               counter_d = '0;
            end
            default: begin
               state_d   = READY;
               counter_d = '0;
            end
         endcase
      end
   end

   always_comb begin
      bus.coolingDown = (state_q != READY);
      bus.framesLeft  = counter_q;
      bus.voteP1      = vote_p1_q;
      bus.voteP2      = vote_p2_q;
      bus.votesP1     = votes_p1_q;
      bus.votesP2     = votes_p2_q;
      bus.winner      = winner_q;
   end

endmodule

// File: tb/tb_election_cooldown.sv
// Bench for election_cooldown: directed scenarios plus random frames, every cycle
// compared against a frame-level behavioural model of the house.
module tb_election_cooldown;
   import election_pkg::*;

   localparam int CF  = 3;
   localparam int MV  = 9;
   localparam int VTW = 2;

   logic clk = 1'b0;
   logic reset;

   election_if bus ();

   election_cooldown #(
      .COOLDOWN_FRAMES (CF),
      .MAX_VOTES       (MV),
      .VOTES_TO_WIN    (VTW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Model: frames of lockout remaining, whether the game is decided, and tallies.
   bit mHit [2];
   int mLock;
   bit mWon;
   int mTally [2];
   int mWinner;
   bit mVote [2];

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic modelClear();
      mHit[0] = 0; mHit[1] = 0;
      mLock = 0; mWon = 0;
      mTally[0] = 0; mTally[1] = 0;
      mWinner = 0;
      mVote[0] = 0; mVote[1] = 0;
   endtask

   task automatic modelStep(input bit rst, input bit ga, input bit sof, input bit c1, input bit c2);
      bit f [2];
      int w;
      if (rst || !ga) begin
         modelClear();
         return;
      end
      mVote[0] = 0;
      mVote[1] = 0;
      if (sof) begin
         f[0] = mHit[0] | c1;
         f[1] = mHit[1] | c2;
         if (mWon) begin
         end else if (mLock > 0) begin
            mLock--;
         end else if (f[0] != f[1]) begin
            w = f[0] ? 0 : 1;
            mVote[w] = 1;
            if (mTally[w] < MV) mTally[w]++;
            if (mTally[w] >= VTW) begin
               mWon = 1;
               mWinner = w + 1;
               mLock = 0;
            end else begin
               mLock = CF;
            end
         end
         mHit[0] = 0;
         mHit[1] = 0;
      end else begin
         mHit[0] |= c1;
         mHit[1] |= c2;
      end
   endtask

   task automatic checkAll();
      checkOutput("coolingDown", bus.coolingDown, (mWon || mLock > 0) ? 1 : 0);
      checkOutput("framesLeft", bus.framesLeft, mWon ? 0 : mLock);
      checkOutput("voteP1", bus.voteP1, mVote[0]);
      checkOutput("voteP2", bus.voteP2, mVote[1]);
      checkOutput("votesP1", bus.votesP1, mTally[0]);
      checkOutput("votesP2", bus.votesP2, mTally[1]);
      checkOutput("winner", bus.winner, mWinner);
   endtask

   // One clock: inputs held across the edge, outputs checked 1 ns after it.
   task automatic applyStimulus(input bit sof, input bit c1, input bit c2);
      bus.startOfFrame = sof;
      bus.collisionP1  = c1;
      bus.collisionP2  = c2;
      @(posedge clk);
      modelStep(reset, bus.gameActive, sof, c1, c2);
      #1;
      checkAll();
   endtask

   // Mid-frame collisions span cycles 1..10; the last cycle carries startOfFrame.
   task automatic runFrame(input int len, input bit mid1, input bit mid2,
                           input bit edge1, input bit edge2);
      for (int i = 0; i < len - 1; i++)
         applyStimulus(1'b0, mid1 && i >= 1 && i <= 10, mid2 && i >= 1 && i <= 10);
      applyStimulus(1'b1, edge1, edge2);
   endtask

   initial begin
      modelClear();
      reset = 1'b1;
      bus.gameActive   = 1'b1;
      bus.startOfFrame = 1'b0;
      bus.collisionP1  = 1'b0;
      bus.collisionP2  = 1'b0;
      applyStimulus(0, 0, 0);
      applyStimulus(0, 0, 0);
      checkOutput("rst_cooling", bus.coolingDown, 0);
      checkOutput("rst_winner", bus.winner, 0);
      reset = 1'b0;

      runFrame(14, 1, 0, 0, 0);
      checkOutput("cap_vote", bus.voteP1, 1);
      checkOutput("cap_tally", bus.votesP1, 1);
      checkOutput("cap_cool", bus.coolingDown, 1);
      checkOutput("cap_frames", bus.framesLeft, CF);

      for (int k = 0; k < 3; k++) begin
         runFrame(14, 1, 0, 0, 0);
         checkOutput("cool_frames", bus.framesLeft, 2 - k);
         checkOutput("cool_novote", bus.voteP1, 0);
      end
      checkOutput("release", bus.coolingDown, 0);

      runFrame(14, 1, 0, 0, 0);
      checkOutput("win_vote", bus.voteP1, 1);
      checkOutput("win_tally", bus.votesP1, 2);
      checkOutput("win_code", bus.winner, WIN_P1);
      checkOutput("win_cool", bus.coolingDown, 1);
      checkOutput("win_frames", bus.framesLeft, 0);

      runFrame(14, 0, 1, 0, 0);
      runFrame(14, 0, 1, 0, 0);
      checkOutput("won_p2tally", bus.votesP2, 0);
      checkOutput("won_sticky", bus.winner, WIN_P1);

      bus.gameActive = 1'b0;
      applyStimulus(0, 0, 0);
      checkOutput("ga_clear_cool", bus.coolingDown, 0);
      checkOutput("ga_clear_tally", bus.votesP1, 0);
      checkOutput("ga_clear_win", bus.winner, 0);
      bus.gameActive = 1'b1;

      runFrame(14, 1, 1, 0, 0);
      checkOutput("contest_v1", bus.voteP1, 0);
      checkOutput("contest_v2", bus.voteP2, 0);
      checkOutput("contest_cool", bus.coolingDown, 0);

      runFrame(14, 0, 1, 1, 0);
      checkOutput("edge_contest", bus.voteP2, 0);
      runFrame(14, 0, 1, 0, 0);
      checkOutput("flags_cleared", bus.voteP2, 1);
      checkOutput("flags_tally", bus.votesP2, 1);

      for (int k = 0; k < 3; k++) runFrame(8, 0, 0, 0, 0);
      checkOutput("p2_release", bus.coolingDown, 0);
      runFrame(8, 0, 0, 0, 1);
      checkOutput("edge_vote", bus.voteP2, 1);
      checkOutput("p2_win", bus.winner, WIN_P2);

      bus.gameActive = 1'b0;
      applyStimulus(0, 0, 0);
      bus.gameActive = 1'b1;
      runFrame(14, 1, 0, 0, 0);
      runFrame(8, 0, 0, 0, 0);
      checkOutput("mid_frames", bus.framesLeft, 2);
      bus.gameActive = 1'b0;
      applyStimulus(0, 0, 0);
      checkOutput("mid_ga_cool", bus.coolingDown, 0);
      checkOutput("mid_ga_frames", bus.framesLeft, 0);
      checkOutput("mid_ga_tally", bus.votesP1, 0);
      bus.gameActive = 1'b1;

      runFrame(14, 1, 0, 0, 0);
      runFrame(8, 0, 0, 0, 0);
      reset = 1'b1;
      applyStimulus(0, 0, 0);
      checkOutput("mid_rst_cool", bus.coolingDown, 0);
      checkOutput("mid_rst_frames", bus.framesLeft, 0);
      checkOutput("mid_rst_tally", bus.votesP1, 0);
      reset = 1'b0;

      for (int n = 0; n < 3000; n++) begin
         reset          = ($urandom_range(0, 299) == 0);
         bus.gameActive = ($urandom_range(0, 199) != 0);
         applyStimulus($urandom_range(0, 7) == 0,
                       $urandom_range(0, 5) == 0,
                       $urandom_range(0, 5) == 0);
      end
      reset = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/election_cooldown.md
# election_cooldown

Frame-based controller for the election house tile. It collects per-pixel tank/house collision strobes over each VGA frame and awards one vote per capture. It then holds the house in a cooldown period for a fixed number of frames and keeps saturating per-player vote tallies. It sits directly upstream of the election house drawing object, which it feeds through `coolingDown`; the vote outputs go to the score/HUD logic.

## Interface
Parameters:
- `COOLDOWN_FRAMES`, default 180: frames the house stays locked after a capture (3 s at 60 Hz); legal range 1..255.
- `MAX_VOTES`, default 9: saturation value of each vote tally.
- `VOTES_TO_WIN`, default 5: tally value that raises `winner`; must be ≤ MAX_VOTES.

Ports:
- `clk`  in  1  system/pixel clock.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `startOfFrame`  in  1  one-cycle pulse at the start of each VGA frame.
- `gameActive`  in  1  level; low forces the idle/cleared condition.
- `collisionP1`  in  1  level; player-1 tank pixel overlaps house pixel this cycle.
- `collisionP2`  in  1  same, for player 2.
- `coolingDown`  out  1  registered; high while the house is locked.
- `framesLeft`  out  8  registered; remaining cooldown frames, 0 when READY.
- `voteP1`  out  1  registered one-cycle pulse: player 1 captured.
- `voteP2`  out  1  same, for player 2.
- `votesP1`  out  4  saturating tally for player 1.
- `votesP2`  out  4  saturating tally for player 2.
- `winner`  out  2  00 none, 01 P1, 10 P2; sticky until reset or `gameActive` low.

## Operation
- Sticky flags `hitP1` and `hitP2` accumulate the collision inputs across a frame.
- On `startOfFrame`, the frame closes. The evaluation uses `hitPx | collisionPx`, so a collision in the `startOfFrame` cycle counts toward the closing frame. Both flags then clear.
- FSM states, from package enum: READY, COOLING, WON.
- READY, frame close:
  - Exactly one player hit: pulse that player's vote, increment its tally, load counter with COOLDOWN_FRAMES, go to COOLING.
  - Both players hit (contested): no vote, stay READY.
  - No hits: stay READY.
- COOLING:
  - Collisions are still accumulated but discarded at each frame close.
  - Each frame close decrements the counter.
  - Close with counter == 1: counter becomes 0, go to READY.
- Tally saturation: a tally at MAX_VOTES stays there and the vote pulse still fires.
- Win: when a tally becomes ≥ VOTES_TO_WIN, set `winner` and go to WON. If both would reach it in the same cycle, that cannot happen, because only one vote is possible per close.
- WON: no further votes; `coolingDown` = 1; `framesLeft` = 0.
- `gameActive` low: synchronously clear flags, counter, tallies and `winner`; state READY; no pulses. This has priority over everything except `reset`.
- `coolingDown` = (state != READY).

## Timing
- Reset values: `coolingDown` 0, `framesLeft` 0, `voteP1` 0, `voteP2` 0, tallies 0, `winner` 00, state READY, flags 0.
- `startOfFrame` in cycle t gives, in cycle t+1:
  - the vote pulse
  - the updated tally
  - `coolingDown` = 1
  - `framesLeft` = COOLDOWN_FRAMES
- Each vote pulse is exactly 1 cycle wide.
- Cooldown release: `coolingDown` falls at t+1 after the COOLDOWN_FRAMES-th subsequent frame close. The first frame close that can award a new vote is the one after the release.
- `reset` or `gameActive` low in the middle of COOLING: outputs return to reset values on the next cycle.

## Structure
- Package `election_pkg`:
  - state enum `election_state_t` {READY, COOLING, WON}
  - `VOTE_W` = 4
  - `FRAME_CNT_W` = 8
  - winner encoding constants
- Sub-module `frame_hit_latch`: sticky flag with set input, clear-on-frame and synchronous reset. It is instantiated once per player.
- Everything else (FSM, counter, tallies) lives in `election_cooldown`.

## Test plan
Bench parameters: COOLDOWN_FRAMES = 3, VOTES_TO_WIN = 2.
- **Single capture:** `collisionP1` for 10 cycles mid-frame, then `startOfFrame` → `voteP1` pulses 1 cycle, `votesP1` = 1, `coolingDown` = 1, `framesLeft` = 3.
- **Cooldown and release:** P1 collisions every frame after the capture → `framesLeft` steps 2, 1, 0 on successive frame closes; no vote during this; the first vote after release arrives at the 5th close overall.
- **Contested frame:** P1 and P2 both collide in READY → no vote pulse, state stays READY, tallies unchanged.
- **Edge collision:** `collisionP2` asserted only in the same cycle as `startOfFrame` → `voteP2` pulses; the next frame's flags are clear.
- **Win:** two P1 captures separated by cooldown → `winner` = 01, `coolingDown` stays 1, further P2 collisions award nothing.
- **Mid-operation clear:** `gameActive` low while `framesLeft` = 2 → next cycle all outputs are 0, state READY; likewise for `reset` asserted mid-COOLING.
